// File: rtl/mult32x32_fast.sv
// mult32x32_fast: sequential unsigned 32x32->64 multiplier.
// One 16x8 partial product (a byte x b half-word) is accumulated per cycle.
// Steps whose operand slice is known zero (captured at start) are skipped,
// so small operands finish in fewer cycles (8 / 4 / 4 / 2).
module mult32x32_fast (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [63:0] product
);

  // Step states encode {j, i} directly in the low three bits; bit 3 marks idle.
  localparam logic [3:0] S_IDLE  = 4'b1000;
  localparam logic [3:0] S_STEP0 = 4'b0000;

  logic [3:0]  state;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        a_small;
  logic        b_small;

  logic [1:0]  idx_i;
  logic        idx_j;
  logic [31:0] a_shift;
  logic [7:0]  a_byte;
  logic [15:0] b_half;
  logic [23:0] pp;
  logic [5:0]  shamt;
  logic [63:0] pp_shifted;
  logic        wrap_i;
  logic        last_step;
  logic [3:0]  state_next;

  assign idx_i = state[1:0];
  assign idx_j = state[2];
  assign busy  = (state != S_IDLE);

  // Select operand slices for the current step and form the shifted partial product.
  always_comb begin
    a_shift    = a_r >> {idx_i, 3'b000};
    a_byte     = a_shift[7:0];
    b_half     = idx_j ? b_r[31:16] : b_r[15:0];
    pp         = {16'd0, a_byte} * {8'd0, b_half};
    shamt      = {1'b0, idx_i, 3'b000} + {1'b0, idx_j, 4'b0000};
    pp_shifted = {40'd0, pp} << shamt;
  end

  // Next non-skipped step: a_small truncates i after 1, b_small ends after j=0.
  always_comb begin
    wrap_i     = (idx_i == 2'd3) || (a_small && (idx_i == 2'd1));
    last_step  = wrap_i && (idx_j || b_small);
    state_next = wrap_i ? {2'b01, 2'b00} : {1'b0, idx_j, idx_i + 2'd1};
  end

  // Control FSM, operand capture and accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      a_small <= 1'b0;
      b_small <= 1'b0;
      product <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        a_r     <= a;
        b_r     <= b;
        a_small <= (a[31:16] == 16'd0);
        b_small <= (b[31:16] == 16'd0);
        product <= '0;
        state   <= S_STEP0;
      end
    end else begin
      product <= product + pp_shifted;
      state   <= last_step ? S_IDLE : state_next;
    end
  end

endmodule

// File: tb/tb_mult32x32_fast.sv
// Scoreboard bench for mult32x32_fast: stimulus pushes expected product and
// busy length; a monitor pops and compares whenever busy falls.
module tb_mult32x32_fast;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [63:0] product;

  mult32x32_fast dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .product (product)
  );

  typedef struct {
    logic [63:0] p;
    int          n;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
  endtask

  // Reference: plain 64-bit product; cycle count from operand magnitudes.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e.p = 64'(x) * 64'(y);
    e.n = ((x < 32'h10000) ? 2 : 4) * ((y < 32'h10000) ? 1 : 2);
    return e;
  endfunction

  // Monitor: count busy cycles and compare on each completion.
  initial begin
    int   cnt;
    logic prev;
    exp_t e;
    cnt  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt  = 0;
        prev = 1'b0;
      end else begin
        if (busy) cnt++;
        if (prev && !busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_completion", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("product", product, e.p);
            check("busy_cycles", 64'(cnt), 64'(e.n));
          end
          cnt = 0;
        end
        prev = busy;
      end
    end
  end

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (busy) check(name, 64'd1, 64'd0);
  endtask

  // One-cycle start pulse; optionally registers an expectation.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input bit expect_done);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    if (expect_done) exp_q.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          t;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_product", product, 64'd0);

    // Fixed vectors, including the known value from the test plan.
    issue(32'd315111401, 32'd318652716, 1'b1);
    wait_idle("timeout_v1");
    check("v1_literal", product, 64'd100411103771215116);
    issue(32'h0000412C, 32'h000037E9, 1'b1);
    wait_idle("timeout_v2");
    check("v2_literal", product, 64'd238798092);
    issue(32'hFFFFFFFF, 32'h0000FFFF, 1'b1);
    wait_idle("timeout_v3");
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_idle("timeout_v4");
    issue(32'h00000000, 32'h00000000, 1'b1);
    wait_idle("timeout_v5");
    issue(32'h0000FFFF, 32'hFFFFFFFF, 1'b1);
    wait_idle("timeout_v6");

    // Start pulse with new operands during an operation must be ignored.
    issue(32'h89ABCDEF, 32'h12345678, 1'b1);
    @(negedge clk);
    a     = 32'hDEADBEEF;
    b     = 32'hCAFEF00D;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("timeout_ignore");

    // start held high: back-to-back operations, one idle cycle between.
    @(negedge clk);
    a     = 32'h00012345;
    b     = 32'h0000ABCD;
    start = 1'b1;
    exp_q.push_back(model(32'h00012345, 32'h0000ABCD));
    exp_q.push_back(model(32'h00012345, 32'h0000ABCD));
    @(negedge clk);
    wait_idle("timeout_held1");
    @(negedge clk);
    check("held_restart_busy", 64'(busy), 64'd1);
    start = 1'b0;
    wait_idle("timeout_held2");

    // Randomized operands with mixed magnitudes.
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 1) == 1) ra = ra & 32'h0000FFFF;
      if ($urandom_range(0, 1) == 1) rb = rb & 32'h0000FFFF;
      if ($urandom_range(0, 9) == 0) ra = 32'd0;
      issue(ra, rb, 1'b1);
      wait_idle("timeout_rand");
    end

    // Reset asserted mid-operation abandons it immediately.
    issue(32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_product", product, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    issue(32'h00001234, 32'h00005678, 1'b1);
    wait_idle("timeout_post_reset");

    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    t = checks;
    $display("%0d/%0d checks passed", passes, t);
    $finish;
  end

endmodule
